// File: rtl/skid_pkg.sv
// ============================================================================
// Module      : skid_pkg
// Description : Shared state encoding and constants for the skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  // Saturation value for the stall counter; users slice it down to CNT_W (max 64).
  localparam logic [63:0] STALL_MAX = '1;

endpackage : skid_pkg

`default_nettype wire

// File: rtl/skid_reg_cell.sv
// ============================================================================
// Module      : skid_reg_cell
// Description : WIDTH-wide data register with load enable and sync reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_reg_cell #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : skid_reg_cell

`default_nettype wire

// File: rtl/skid_register.sv
// ============================================================================
// Module      : skid_register
// Description : Two-entry valid/ready skid buffer with registered I_ready,
//               saturating stall counter and inline handshake assertions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module skid_register
  import skid_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] I,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  input  logic             O_ready,
  output logic [CNT_W-1:0] STALL_CNT
);

  localparam logic [CNT_W-1:0] c_stall_max = STALL_MAX[CNT_W-1:0];

  skid_state_t      r_state;
  skid_state_t      w_state_next;
  logic             r_i_ready;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_load;
  logic             w_unload;
  logic             w_main_en;
  logic             w_skid_en;
  logic             w_main_from_skid;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign w_load   = I_valid & r_i_ready;
  assign w_unload = O_valid & O_ready;

  // ---------------------------------------------------------------------------
  // Data path: main always drives O; skid only holds the overflow word.
  // ---------------------------------------------------------------------------
  assign w_main_d = w_main_from_skid ? w_skid_q : I;

  skid_reg_cell #(
    .WIDTH (WIDTH)
  ) u_main (
    .CLK   (CLK),
    .RESET (RESET),
    .i_en  (w_main_en),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  skid_reg_cell #(
    .WIDTH (WIDTH)
  ) u_skid (
    .CLK   (CLK),
    .RESET (RESET),
    .i_en  (w_skid_en),
    .i_d   (I),
    .o_q   (w_skid_q)
  );

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_main_en        = 1'b0;
    w_skid_en        = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_load) begin
          w_main_en    = 1'b1;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        if (w_load && !w_unload) begin
          w_skid_en    = 1'b1;
          w_state_next = FULL;
        end else if (!w_load && w_unload) begin
          w_state_next = EMPTY;
        end else if (w_load && w_unload) begin
          w_main_en    = 1'b1;
        end
      end
      FULL: begin
        // I_ready is low here, so only the drain of the skid word can happen.
        if (w_unload) begin
          w_main_en        = 1'b1;
          w_main_from_skid = 1'b1;
          w_state_next     = BUSY;
        end
      end
      default: begin
        w_state_next = EMPTY;
      end
    endcase
  end

  // Ready is computed from the next state so the upstream sees a pure flop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_i_ready <= 1'b1;
    end else begin
      r_i_ready <= (w_state_next != FULL);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stall_cnt <= '0;
    end else if (O_valid && !O_ready && (r_stall_cnt != c_stall_max)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign O         = w_main_q;
  assign O_valid   = (r_state != EMPTY);
  assign I_ready   = r_i_ready;
  assign STALL_CNT = r_stall_cnt;

  // ---------------------------------------------------------------------------
  // Handshake contract
  // ---------------------------------------------------------------------------
  property p_stall_holds;
    @(posedge CLK) disable iff (RESET)
      (O_valid && !O_ready) |=> (O_valid && $stable(O));
  endproperty

  property p_load_visible;
    @(posedge CLK) disable iff (RESET)
      (I_valid && I_ready) |=> O_valid;
  endproperty

  property p_full_not_ready;
    @(posedge CLK) disable iff (RESET)
      !((r_state == FULL) && r_i_ready);
  endproperty

  a_stall_holds:    assert property (p_stall_holds);
  a_load_visible:   assert property (p_load_visible);
  a_full_not_ready: assert property (p_full_not_ready);

endmodule : skid_register

`default_nettype wire
